// File: rtl/mealey_decimator.sv
// Block-sum decimator for the Mealey stage output with a small result FIFO.
// Define MEALEY_DEC_AVG_EN to emit the rounded block average instead of the saturated sum.
module mealey_decimator #(
   parameter int unsigned DEC_LOG2   = 2,
   parameter int unsigned OUT_W      = 12,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             system1000,
   input  logic             system1000_rstn,
   input  logic [8:0]       in_data,
   input  logic             in_valid,
   input  logic             clear,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow
);

   localparam int unsigned ACC_W   = 9 + DEC_LOG2;
   localparam int unsigned CNT_W   = DEC_LOG2;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W  = PTR_W + 1;
   localparam int unsigned CMP_W   = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam int unsigned RND_W   = ACC_W + 1;

   localparam logic signed [CMP_W-1:0] OUT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CMP_W-1:0] OUT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [RND_W-1:0] HALF    = RND_W'(1) << (DEC_LOG2 - 1);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_c;
   logic [FCNT_W-1:0]       count_q, count_d;
   logic [OUT_W-1:0]        out_data_q, out_data_d, head_c;
   logic                    out_valid_q, out_valid_d;
   logic                    overflow_q, overflow_d;

   logic signed [ACC_W-1:0] sum_c;
   logic signed [CMP_W-1:0] sum_w_c;
   logic signed [RND_W-1:0] rnd_c;
   logic [OUT_W-1:0]        result_c;
   logic                    close_c, full_c, pop_c, push_c, drop_c;

   // Block sum and its conversion to an output word
   always_comb begin
      sum_c   = acc_q + ACC_W'(signed'(in_data));
      sum_w_c = CMP_W'(sum_c);
      rnd_c   = RND_W'(sum_c) + HALF;
`ifdef MEALEY_DEC_AVG_EN
      result_c = OUT_W'(rnd_c >>> DEC_LOG2);
`else
      if (sum_w_c > OUT_MAX) begin
         result_c = OUT_W'(OUT_MAX);
      end else if (sum_w_c < OUT_MIN) begin
         result_c = OUT_W'(OUT_MIN);
      end else begin
         result_c = OUT_W'(sum_w_c);
      end
`endif
   end

   // Accumulator, FIFO control and the registered head view
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      head_c      = result_c;
      rd_nxt_c    = PTR_W'(rd_ptr_q + 1'b1);

      close_c = in_valid && (&cnt_q);
      full_c  = (count_q == FCNT_W'(FIFO_DEPTH));
      pop_c   = out_valid_q && out_ready && !clear;
      push_c  = close_c && !clear && (!full_c || pop_c);
      drop_c  = close_c && !clear && full_c && !pop_c;

      if (clear) begin
         acc_d       = '0;
         cnt_d       = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (in_valid) begin
            acc_d = close_c ? '0 : sum_c;
            cnt_d = CNT_W'(cnt_q + 1'b1);
         end
         if (pop_c)  rd_ptr_d = rd_nxt_c;
         if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
         if (drop_c) overflow_d = 1'b1;
         count_d = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);

         // New head: next stored entry, the surviving head, or the value pushed into an empty slot
         if (pop_c) begin
            head_c = (count_q > FCNT_W'(1)) ? mem_q[rd_nxt_c] : result_c;
         end else begin
            head_c = (count_q != '0) ? mem_q[rd_ptr_q] : result_c;
         end
         if (count_d != '0) out_data_d = head_c;
         out_valid_d = (count_d != '0);
      end
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         if (push_c) mem_q[wr_ptr_q] <= result_c;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

endmodule
